mul_booth_iter: RTL and testbench

Iterative radix-4 Booth multiplier for the RV64M datapath in the EXU; it is the sequential consumer of the per-digit Booth partial-product selector. One multiplicand multiple is selected and accumulated per cycle, covering MUL/MULH/MULHSU/MULHU through sign-control and high/low select. It sits between the EXU issue handshake and the EXU writeback mux. It replaces a single-cycle array where timing does not allow one.

---
 rtl/mul_booth_iter.sv | 122 ++++++++++++
 tb/tb_mul_booth_iter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_booth_iter.sv
// Iterative radix-4 Booth multiplier: one Booth digit is accumulated per cycle.
// Covers signed/unsigned operand combinations and high/low product selection.
module mul_booth_iter #(
    parameter int WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_x_signed,
    input  logic             i_y_signed,
    input  logic             i_hi,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result
);

    localparam int N    = (WIDTH + 2) / 2;
    localparam int ACCW = 2 * WIDTH + 4;
    localparam int EXTW = WIDTH + 2;
    localparam int QW   = WIDTH + 3;
    localparam int CNTW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_reg, state_next;
    logic [ACCW-1:0]   p_reg, m_reg;
    logic [QW-1:0]     q_reg;
    logic [CNTW-1:0]   cnt_reg;
    logic              hi_reg;

    logic              accept;
    logic              last_iter;
    logic [EXTW-1:0]   x_ext, y_ext;
    logic [ACCW-1:0]   m2, pp, p_sum;
    logic              clow;

    assign accept    = i_valid & (state_reg == IDLE) & ~i_flush;
    assign last_iter = (cnt_reg == CNTW'(N - 1));

    // Two extra bits make unsigned operands look like positive signed ones.
    assign x_ext = {{2{i_x_signed & i_x[WIDTH-1]}}, i_x};
    assign y_ext = {{2{i_y_signed & i_y[WIDTH-1]}}, i_y};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (i_flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (accept)    state_next = BUSY;
                BUSY:    if (last_iter) state_next = DONE;
                DONE:    if (i_ready)   state_next = IDLE;
                default:                state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        o_ready = (state_reg == IDLE);
        o_valid = (state_reg == DONE);
    end

    // Booth digit selector: negative multiples use one's complement plus carry-in.
    assign m2 = {m_reg[ACCW-2:0], 1'b0};

    always_comb begin
        pp   = '0;
        clow = 1'b0;
        case (q_reg[2:0])
            3'b001, 3'b010: pp = m_reg;
            3'b011:         pp = m2;
            3'b100: begin
                pp   = ~m2;
                clow = 1'b1;
            end
            3'b101, 3'b110: begin
                pp   = ~m_reg;
                clow = 1'b1;
            end
            default:        pp = '0;
        endcase
    end

    assign p_sum = p_reg + pp + ACCW'(clow);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            p_reg   <= '0;
            m_reg   <= '0;
            q_reg   <= '0;
            cnt_reg <= '0;
            hi_reg  <= 1'b0;
        end else if (accept) begin
            p_reg   <= '0;
            m_reg   <= {{(ACCW - EXTW){x_ext[EXTW-1]}}, x_ext};
            q_reg   <= {y_ext, 1'b0};
            cnt_reg <= '0;
            hi_reg  <= i_hi;
        end else if (state_reg == BUSY && !i_flush) begin
            p_reg   <= p_sum;
            m_reg   <= {m_reg[ACCW-3:0], 2'b00};
            q_reg   <= {{2{q_reg[QW-1]}}, q_reg[QW-1:2]};
            cnt_reg <= cnt_reg + CNTW'(1);
        end
    end

    // P is frozen outside BUSY, so the result holds for the whole DONE phase.
    assign o_result = hi_reg ? p_reg[2*WIDTH-1:WIDTH] : p_reg[WIDTH-1:0];

endmodule

// File: tb/tb_mul_booth_iter.sv
// Directed bench for mul_booth_iter at WIDTH=64: products, latency and control.
module tb_mul_booth_iter;

    localparam int WIDTH = 64;
    localparam int N     = 33;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_x;
    logic [WIDTH-1:0] i_y;
    logic             i_x_signed;
    logic             i_y_signed;
    logic             i_hi;
    logic             i_flush;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_result;

    int checks   = 0;
    int failures = 0;

    mul_booth_iter #(.WIDTH(WIDTH)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_x        (i_x),
        .i_y        (i_y),
        .i_x_signed (i_x_signed),
        .i_y_signed (i_y_signed),
        .i_hi       (i_hi),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [63:0] x;
        logic [63:0] y;
        logic        xs;
        logic        ys;
        logic        hi;
        logic [63:0] e;
    } vec_t;

    function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                            input logic xs, input logic ys, input logic hi);
        logic [129:0] a, b, p;
        a = {{66{xs & x[63]}}, x};
        b = {{66{ys & y[63]}}, y};
        p = a * b;
        return hi ? p[127:64] : p[63:0];
    endfunction

    // Issues one request from IDLE and waits (bounded) until DONE; leaves it in DONE.
    task automatic run_op(input logic [63:0] x, input logic [63:0] y, input logic xs,
                          input logic ys, input logic hi, output logic [63:0] res,
                          output int lat, output bit tmo, output bit rdy_bad);
        i_x = x; i_y = y; i_x_signed = xs; i_y_signed = ys; i_hi = hi; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_x = {$urandom, $urandom};
        i_y = {$urandom, $urandom};
        i_hi = ~hi;
        lat = 0; tmo = 1'b0; rdy_bad = 1'b0;
        while (!o_valid && lat < 100) begin
            if (o_ready) rdy_bad = 1'b1;
            @(posedge i_clk); #1;
            lat++;
        end
        if (!o_valid) tmo = 1'b1;
        if (o_ready) rdy_bad = 1'b1;
        res = o_result;
        $display("op x=%h y=%h xs=%0d ys=%0d hi=%0d -> result=%h latency=%0d",
                 x, y, xs, ys, hi, res, lat);
    endtask

    task automatic ack();
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        checks++; if (o_result !== 64'd0) begin failures++; $display("FAIL reset_result: got %h expected 0", o_result); end
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %b expected 1", o_ready); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid: got %b expected 0", o_valid); end
    endtask

    task automatic test_basic();
        logic [63:0] res; int lat; bit tmo, rb;
        run_op(64'd3, 64'd5, 1'b0, 1'b0, 1'b0, res, lat, tmo, rb);
        checks++; if (tmo) begin failures++; $display("FAIL basic_timeout: got no o_valid expected o_valid within 100 cycles"); end
        checks++; if (res !== 64'd15) begin failures++; $display("FAIL basic_result: got %h expected %h", res, 64'd15); end
        checks++; if (lat != N) begin failures++; $display("FAIL basic_latency: got %0d expected %0d", lat, N); end
        checks++; if (rb) begin failures++; $display("FAIL basic_ready_low: got o_ready=1 in BUSY/DONE expected 0"); end
        ack();
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_after_ack: got %b expected 1", o_ready); end
    endtask

    task automatic test_ops();
        vec_t v[12];
        logic [63:0] res; int lat; bit tmo, rb;
        v[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 64'd1};
        v[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1, 64'd0};
        v[2]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
        v[3]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 64'd1};
        v[4]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        v[5]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b1, 64'h4000_0000_0000_0000};
        v[6]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 64'd0};
        v[7]  = '{64'h8000_0000_0000_0000, 64'd2, 1'b0, 1'b0, 1'b1, 64'd1};
        v[8]  = '{64'h8000_0000_0000_0000, 64'd2, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        v[9]  = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB};
        v[10] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1'b0, 1'b0, 1'b1, 64'd6};
        v[11] = '{64'h0000_0000_0000_1234, 64'd0, 1'b1, 1'b1, 1'b0, 64'd0};
        for (int i = 0; i < 12; i++) begin
            run_op(v[i].x, v[i].y, v[i].xs, v[i].ys, v[i].hi, res, lat, tmo, rb);
            checks++;
            if (tmo || res !== v[i].e) begin
                failures++;
                $display("FAIL ops[%0d]: got %h (timeout=%0d) expected %h", i, res, tmo, v[i].e);
            end
            ack();
        end
    endtask

    task automatic test_hold();
        logic [63:0] res; int lat; bit tmo, rb;
        bit unstable;
        run_op(64'h0000_0001_0000_0001, 64'h10, 1'b0, 1'b0, 1'b0, res, lat, tmo, rb);
        checks++; if (tmo || res !== 64'h0000_0010_0000_0010) begin failures++; $display("FAIL hold_result: got %h expected %h", res, 64'h0000_0010_0000_0010); end
        unstable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            i_x = {$urandom, $urandom};
            i_hi = ~i_hi;
            @(posedge i_clk); #1;
            if (o_valid !== 1'b1 || o_result !== 64'h0000_0010_0000_0010) unstable = 1'b1;
        end
        checks++; if (unstable) begin failures++; $display("FAIL hold_stable: got valid=%b result=%h expected held valid=1 result=%h", o_valid, o_result, 64'h0000_0010_0000_0010); end
        ack();
    endtask

    task automatic test_flush();
        bit seen_valid;
        i_x = 64'd11; i_y = 64'd13; i_x_signed = 1'b0; i_y_signed = 1'b0; i_hi = 1'b0;
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (10) @(posedge i_clk);
        #1;
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL flush_busy: got o_ready=%b expected 0", o_ready); end
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL flush_ready: got %b expected 1", o_ready); end
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (o_valid) seen_valid = 1'b1;
            @(posedge i_clk); #1;
        end
        checks++; if (seen_valid) begin failures++; $display("FAIL flush_no_valid: got o_valid=1 expected never"); end
    endtask

    task automatic test_flush_accept();
        bit seen_busy;
        i_x = 64'd2; i_y = 64'd2;
        i_valid = 1'b1; i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        seen_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!o_ready || o_valid) seen_busy = 1'b1;
            @(posedge i_clk); #1;
        end
        checks++; if (seen_busy) begin failures++; $display("FAIL flush_accept: got request accepted expected ignored"); end
    endtask

    task automatic test_async_reset();
        i_x = 64'd3; i_y = 64'd5; i_x_signed = 1'b0; i_y_signed = 1'b0; i_hi = 1'b0;
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (5) @(posedge i_clk);
        #3;
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL areset_pre_busy: got o_ready=%b expected 0", o_ready); end
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL areset_ready: got %b expected 1", o_ready); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL areset_valid: got %b expected 0", o_valid); end
        checks++; if (o_result !== 64'd0) begin failures++; $display("FAIL areset_result: got %h expected 0", o_result); end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [63:0] res; int lat; bit tmo, rb;
        run_op(64'd3, 64'd5, 1'b0, 1'b0, 1'b0, res, lat, tmo, rb);
        checks++; if (tmo || res !== 64'd15) begin failures++; $display("FAIL b2b_first: got %h expected %h", res, 64'd15); end
        i_x = 64'd7; i_y = 64'd9; i_x_signed = 1'b0; i_y_signed = 1'b0; i_hi = 1'b0;
        i_valid = 1'b1; i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin failures++; $display("FAIL b2b_no_reaccept: got ready=%b valid=%b expected ready=1 valid=0", o_ready, o_valid); end
        run_op(64'd7, 64'd9, 1'b0, 1'b0, 1'b0, res, lat, tmo, rb);
        checks++; if (tmo || res !== 64'd63) begin failures++; $display("FAIL b2b_second: got %h expected %h", res, 64'd63); end
        checks++; if (lat != N) begin failures++; $display("FAIL b2b_latency: got %0d expected %0d", lat, N); end
        ack();
    endtask

    task automatic test_random();
        logic [63:0] x, y, res, e; logic xs, ys, hi; int lat; bit tmo, rb;
        for (int i = 0; i < 200; i++) begin
            x = {$urandom, $urandom}; y = {$urandom, $urandom};
            if (i % 8 == 0) x = 64'h8000_0000_0000_0000;
            if (i % 16 == 1) y = 64'hFFFF_FFFF_FFFF_FFFF;
            xs = i[0]; ys = i[1]; hi = i[2];
            e = ref_mul(x, y, xs, ys, hi);
            run_op(x, y, xs, ys, hi, res, lat, tmo, rb);
            checks++;
            if (tmo || res !== e) begin
                failures++;
                $display("FAIL random[%0d]: got %h expected %h", i, res, e);
            end
            ack();
        end
    endtask

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_x = '0; i_y = '0;
        i_x_signed = 1'b0; i_y_signed = 1'b0; i_hi = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        @(posedge i_clk); #1;
        test_reset();
        test_basic();
        test_ops();
        test_hold();
        test_flush();
        test_flush_accept();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
